// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_pkg
// Description : Shared defaults and the address-width derivation for the
//               synchronous FIFO and its storage array.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

  localparam int C_DATA_W_DEFAULT = 6;
  localparam int C_DEPTH_DEFAULT  = 64;

  // Number of address bits needed to index 'depth' words (ceil(log2)).
  function automatic int addr_width(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage : sync_fifo_pkg
`default_nettype wire

// File: rtl/sync_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ram
// Description : Simple dual-port storage array: one write port and one
//               registered, enabled read port. No reset, so it maps onto
//               block RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ram #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [0:(1 << ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  // Write port: store the word when the controller accepts a write.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Read port: registered output that only changes on an enabled read.
  always_ff @(posedge clk) begin
    if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule : sync_fifo_ram
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered count/full/empty flags,
//               one-cycle read latency and overflow/underflow pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter  int DATA_W = C_DATA_W_DEFAULT,
  parameter  int DEPTH  = C_DEPTH_DEFAULT,
  localparam int ADDR_W = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   data_count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] C_ONE   = (ADDR_W+1)'(1);

  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_valid;
  logic              r_overflow;
  logic              r_underflow;
  // Set by reset, cleared by the first accepted read: masks the
  // unreset RAM output so dout reads as zero until real data arrives.
  logic              r_dout_zero;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [ADDR_W:0]   w_count_nxt;
  logic [DATA_W-1:0] w_ram_q;

  assign w_wr_acc = wr_en & ~r_full;
  assign w_rd_acc = rd_en & ~r_empty;

  // Next occupancy: a simultaneous accepted read and write cancel out.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + C_ONE;
      2'b01:   w_count_nxt = r_count - C_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, occupancy, flags and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_dout_zero <= 1'b1;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + C_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr    <= r_rd_ptr + C_ONE;
        r_dout_zero <= 1'b0;
      end
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == C_DEPTH);
      r_empty     <= (w_count_nxt == '0);
      r_valid     <= w_rd_acc;
      r_overflow  <= wr_en & r_full;
      r_underflow <= rd_en & r_empty;
    end
  end

  // Requests in a reset cycle must not touch storage or the read register.
  sync_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_wr_acc & ~rst),
    .waddr (r_wr_ptr[ADDR_W-1:0]),
    .wdata (din),
    .re    (w_rd_acc & ~rst),
    .raddr (r_rd_ptr[ADDR_W-1:0]),
    .rdata (w_ram_q)
  );

  assign dout       = r_dout_zero ? '0 : w_ram_q;
  assign valid      = r_valid;
  assign full       = r_full;
  assign empty      = r_empty;
  assign data_count = r_count;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

endmodule : sync_fifo
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo
// Description : Scoreboard bench for sync_fifo with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

  localparam int DATA_W = 6;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] din;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              valid;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   data_count;
  logic              overflow;
  logic              underflow;

  int tests = 0;
  int fails = 0;

  // Reference contents and expected read responses.
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] exp_q[$];
  int                mc = 0;
  int                peak = 0;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .dout       (dout),
    .valid      (valid),
    .full       (full),
    .empty      (empty),
    .data_count (data_count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid word must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL read_data: got unexpected word %0d with nothing expected", dout);
      end else begin
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          fails++;
          $display("FAIL read_data: got %0d expected %0d at %0t", dout, e, $time);
        end
      end
    end
  end

  // One clock of stimulus, model update and flag checks.
  task automatic step(input logic wr, input logic rd, input logic [DATA_W-1:0] d);
    bit wa, ra, e_ovf, e_udf;
    logic [DATA_W-1:0] prev_dout;
    wa = wr && (mc < DEPTH);
    ra = rd && (mc > 0);
    e_ovf = wr && (mc == DEPTH);
    e_udf = rd && (mc == 0);
    prev_dout = dout;
    wr_en = wr; rd_en = rd; din = d;
    if (ra) exp_q.push_back(mq.pop_front());
    if (wa) mq.push_back(d);
    mc = mc + int'(wa) - int'(ra);
    if (mc > peak) peak = mc;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    chk("data_count", int'(data_count), mc);
    chk("full", int'(full), int'(mc == DEPTH));
    chk("empty", int'(empty), int'(mc == 0));
    chk("overflow", int'(overflow), int'(e_ovf));
    chk("underflow", int'(underflow), int'(e_udf));
    if (!ra) chk("dout_hold", int'(dout), int'(prev_dout));
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; din = 6'h15;
    @(posedge clk); #1;
    chk("rst_count", int'(data_count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_udf", int'(underflow), 0);
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    mq.delete(); exp_q.delete(); mc = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Ordered fill of 32 then drain of 32.
    peak = 0;
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0, DATA_W'(i));
    chk("peak_count", peak, 32);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);
    chk("empty_after_drain", int'(empty), 1);
    chk("last_word", int'(dout), 31);

    // Read while empty: underflow pulse, no valid, dout held.
    step(1'b0, 1'b1, '0);
    chk("udf_valid", int'(valid), 0);
    chk("udf_dout", int'(dout), 31);
    step(1'b0, 1'b0, '0);

    // Fill to full, then a rejected write.
    for (int i = 0; i < 64; i++) step(1'b1, 1'b0, DATA_W'(i));
    chk("full_set", int'(full), 1);
    step(1'b1, 1'b0, 6'h3F);
    chk("ovf_count", int'(data_count), 64);
    step(1'b0, 1'b0, '0);

    // Full with simultaneous read and write: oldest word out, write rejected.
    step(1'b1, 1'b1, 6'h3E);
    chk("full_rw_count", int'(data_count), 63);
    chk("full_rw_overflow", int'(overflow), 1);
    chk("full_rw_dout", int'(dout), 0);
    for (int i = 0; i < 63; i++) step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);

    // Empty with simultaneous read and write: write in, no write-through.
    step(1'b1, 1'b1, 6'h2B);
    chk("empty_rw_valid", int'(valid), 0);
    step(1'b0, 1'b1, '0);
    chk("empty_rw_dout", int'(dout), 6'h2B);

    // Steady state at 10 with concurrent read/write across pointer wrap.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, DATA_W'(i));
    for (int i = 10; i < 110; i++) step(1'b1, 1'b1, DATA_W'(i));
    chk("steady_count", int'(data_count), 10);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);

    // Mid-stream reset discards contents; next write reads back.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, DATA_W'(i + 7));
    do_reset();
    step(1'b1, 1'b0, 6'h2A);
    step(1'b0, 1'b1, '0);
    chk("post_rst_dout", int'(dout), 6'h2A);
    step(1'b0, 1'b0, '0);

    step(1'b0, 1'b0, '0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_sync_fifo
`default_nettype wire

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATA_W, default 6, data word width in bits.
REQ-002 Parameter DEPTH, default 64, number of storage words; SHALL be a power of two, minimum 4.
REQ-003 Parameter ADDR_W, default log2(DEPTH)=6, RAM address width; derived, not overridden.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 din  input  DATA_W  write data, sampled with wr_en.
REQ-007 wr_en  input  1  write request.
REQ-008 rd_en  input  1  read request.
REQ-009 dout  output  DATA_W  read data, registered.
REQ-010 valid  output  1  dout holds a newly read word this cycle.
REQ-011 full  output  1  no free slot.
REQ-012 empty  output  1  no stored word.
REQ-013 data_count  output  ADDR_W+1  words currently stored, 0..DEPTH.
REQ-014 overflow  output  1  one-cycle pulse: a write was rejected last cycle.
REQ-015 underflow  output  1  one-cycle pulse: a read was rejected last cycle.

Function
REQ-016 A write SHALL be accepted iff wr_en=1 and full=0; din is stored at wr_ptr, and wr_ptr increments.
REQ-017 A read SHALL be accepted iff rd_en=1 and empty=0; the word at rd_ptr is presented on dout the next cycle, and rd_ptr increments.
REQ-018 Read latency SHALL be exactly 1 cycle: accepted read in cycle N gives dout and valid=1 in cycle N+1.
REQ-019 dout SHALL hold its last value when no read is accepted; valid SHALL be 0 in that cycle.
REQ-020 wr_ptr and rd_ptr SHALL be ADDR_W+1 bits, wrapping modulo 2*DEPTH; the RAM address is the low ADDR_W bits.
REQ-021 data_count SHALL be registered: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-022 full SHALL be registered and equal (data_count==DEPTH) in the same cycle; empty SHALL be registered and equal (data_count==0).
REQ-023 When write and read are both accepted in the same cycle, data_count, full and empty SHALL be unchanged.
REQ-024 When full=1, a read and a write in the same cycle: the read is accepted, the write is rejected, and overflow=1 next cycle.
REQ-025 When empty=1, a read and a write in the same cycle: the write is accepted, the read is rejected, underflow=1 next cycle, and there is no write-through to dout.
REQ-026 Rejected requests SHALL NOT change pointers, count or RAM contents.
REQ-027 Data SHALL leave in exact write order with no loss across pointer wrap.

Reset
REQ-028 While rst=1: wr_ptr=0, rd_ptr=0, data_count=0, empty=1, full=0, dout=0, valid=0, overflow=0, underflow=0.
REQ-029 Reset mid-operation SHALL discard all stored words; RAM contents are not cleared.
REQ-030 Requests presented in a reset cycle SHALL be ignored; operation resumes on the first cycle with rst=0.

Structure
REQ-031 Package sync_fifo_pkg SHALL hold the DATA_W and DEPTH defaults and the ADDR_W derivation function.
REQ-032 Storage SHALL be sub-module sync_fifo_ram: simple dual-port, one write port and one registered read port, no reset, inferable as block RAM.
REQ-033 Pointers, count, flags and pulse logic SHALL reside in sync_fifo; there is no other hierarchy.

Verification
REQ-034 After reset, write 0..31 over 32 cycles, then read 32 -> dout=0..31 in order, each one cycle after its read; empty=1 after the last read; data_count peaks at 32.
REQ-035 Write 64 words (0..63) -> full=1 in the cycle after the 64th write; a 65th write gives overflow=1 for 1 cycle and data_count stays 64.
REQ-036 Read while empty -> underflow=1 for 1 cycle, valid=0, dout unchanged, rd_ptr unchanged.
REQ-037 Hold count at 10, then assert wr_en and rd_en together for 100 cycles with an incrementing din -> data_count stays 10, the output sequence is continuous, and both pointers wrap correctly.
REQ-038 Write 20 words, assert rst for 1 cycle mid-stream -> empty=1, data_count=0, dout=0; the next write of 0x2A reads back 0x2A.
REQ-039 At full, wr_en and rd_en together -> the read returns the oldest word, overflow=1, data_count=63.
